// File: rtl/spi_pix_injector.sv
// SPI command decoder and pixel injector: register burst read/write, multi-byte pixel assembly, camera/SPI mux.
// tx_dat, register writes and the spi pixel pulse all land one cycle after byte_vld; there is no backpressure, so one byte per cycle is accepted.
module spi_pix_injector #(
  parameter int PIX_BYTES = 6,
  parameter int REG_AW    = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_css,
  input  logic                        i_byte_vld,
  input  logic [7:0]                  i_byte_dat,
  output logic [7:0]                  o_tx_dat,
  input  logic [7:0]                  i_ret_dat,
  input  logic                        i_cam_dv,
  input  logic                        i_cam_rst,
  input  logic [PIX_BYTES*8-1:0]      i_cam_dat,
  output logic                        o_out_vld,
  output logic                        o_out_rst,
  output logic [PIX_BYTES*8-1:0]      o_out_dat,
  output logic [(2**REG_AW)*8-1:0]    o_cfg
);

  localparam int REG_N = 2**REG_AW;
  localparam int PW    = PIX_BYTES*8;
  localparam int BCW   = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
  localparam logic [REG_AW-1:0] STAT_IDX = REG_AW'(REG_N-1);
  localparam logic [BCW-1:0]    BC_LAST  = BCW'(PIX_BYTES-1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_WR_A, S_WR_BURST, S_CMD_RD_A, S_RD_BURST, S_STREAM, S_DROP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_reg [REG_N];
  logic [REG_AW-1:0]   r_ptr;
  logic [BCW-1:0]      r_bc;
  logic [PW-1:0]       r_pix_sr;
  logic [PW-1:0]       r_spi_pix;
  logic                r_spi_vld;
  logic                r_scr_rst;
  logic                r_perr;
  logic [7:0]          r_tx_dat;

  logic [7:0]          w_status;
  logic [REG_AW-1:0]   w_rd_idx;
  logic [7:0]          w_rd_val;
  logic [PW-1:0]       w_pix_shift;
  logic                w_src_spi;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_css) begin
      w_state_nxt = S_IDLE;
    end else if (i_byte_vld) begin
      case (r_state)
        S_IDLE: begin
          case (i_byte_dat)
            8'h80:   w_state_nxt = S_CMD_WR_A;
            8'h81:   w_state_nxt = S_CMD_RD_A;
            8'h55:   w_state_nxt = S_STREAM;
            default: w_state_nxt = S_DROP;
          endcase
        end
        S_CMD_WR_A: w_state_nxt = S_WR_BURST;
        S_CMD_RD_A: w_state_nxt = S_RD_BURST;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  assign w_status    = {5'b0, r_scr_rst, (r_state == S_STREAM), r_perr};
  assign w_rd_idx    = (r_state == S_CMD_RD_A) ? i_byte_dat[REG_AW-1:0] : r_ptr;
  assign w_rd_val    = (w_rd_idx == STAT_IDX) ? w_status : r_reg[w_rd_idx];
  // First byte of a pixel ends up in the MSB after PIX_BYTES shifts.
  assign w_pix_shift = (r_pix_sr << 8) | PW'(i_byte_dat);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < REG_N; k++) r_reg[k] <= 8'h00;
      r_ptr     <= '0;
      r_bc      <= '0;
      r_pix_sr  <= '0;
      r_spi_pix <= '0;
      r_spi_vld <= 1'b0;
      r_scr_rst <= 1'b0;
      r_perr    <= 1'b0;
      r_tx_dat  <= 8'hFF;
    end else begin
      r_spi_vld <= 1'b0;
      if (!i_css) begin
        // A transaction ending mid-pixel drops the partial bytes and flags it.
        r_bc <= '0;
        if (r_state == S_STREAM && r_bc != '0) r_perr <= 1'b1;
      end else if (i_byte_vld) begin
        case (r_state)
          S_IDLE: begin
            r_tx_dat <= 8'hFF;
            if (i_byte_dat == 8'h40) r_scr_rst <= 1'b0;
            if (i_byte_dat == 8'h41) r_scr_rst <= 1'b1;
          end
          S_CMD_WR_A: r_ptr <= i_byte_dat[REG_AW-1:0];
          S_WR_BURST: begin
            if (r_ptr == STAT_IDX) r_perr <= 1'b0;
            else                   r_reg[r_ptr] <= i_byte_dat;
            r_ptr <= r_ptr + REG_AW'(1);
          end
          S_CMD_RD_A: begin
            r_tx_dat <= w_rd_val;
            r_ptr    <= i_byte_dat[REG_AW-1:0] + REG_AW'(1);
          end
          S_RD_BURST: begin
            r_tx_dat <= w_rd_val;
            r_ptr    <= r_ptr + REG_AW'(1);
          end
          S_STREAM: begin
            r_tx_dat <= i_ret_dat;
            r_pix_sr <= w_pix_shift;
            if (r_bc == BC_LAST) begin
              r_spi_pix <= w_pix_shift;
              r_spi_vld <= 1'b1;
              r_bc      <= '0;
            end else begin
              r_bc <= r_bc + BCW'(1);
            end
          end
          default: r_tx_dat <= 8'hFF;
        endcase
      end
    end
  end

  always_comb begin
    o_cfg = '0;
    for (int k = 0; k < REG_N-1; k++) o_cfg[k*8 +: 8] = r_reg[k];
    o_cfg[(REG_N-1)*8 +: 8] = w_status;
  end

  assign w_src_spi = r_reg[0][0];
  assign o_tx_dat  = r_tx_dat;
  assign o_out_vld = w_src_spi ? r_spi_vld : i_cam_dv;
  assign o_out_rst = w_src_spi ? r_scr_rst : i_cam_rst;
  assign o_out_dat = w_src_spi ? r_spi_pix : i_cam_dat;

endmodule

// File: tb/tb_spi_pix_injector.sv
// Directed bench for spi_pix_injector (PIX_BYTES=6, REG_AW=3): vector table plus corner-case sequences.
module tb_spi_pix_injector;

  localparam logic [47:0] CAM  = 48'h1122_3344_5566;
  localparam logic [47:0] PIX1 = 48'h0102_0304_0506;
  localparam logic [47:0] PIX2 = 48'h0708_090A_0B0C;
  localparam logic [63:0] CW   = 64'h00A1_5A00_0000_00C3;
  localparam logic [63:0] CS   = 64'h02A1_5A00_0000_00C3;

  logic        clk = 1'b0;
  logic        rst, css, byte_vld, cam_dv, cam_rst;
  logic [7:0]  byte_dat, ret_dat, tx_dat;
  logic [47:0] cam_dat, out_dat;
  logic        out_vld, out_rst;
  logic [63:0] cfg;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        css;
    logic        vld;
    logic [7:0]  b;
    logic [7:0]  ret;
    logic [7:0]  tx;
    logic [63:0] cfg;
    logic        ov;
    logic [47:0] od;
  } vec_t;

  vec_t tbl[$];

  spi_pix_injector #(.PIX_BYTES(6), .REG_AW(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_css(css), .i_byte_vld(byte_vld), .i_byte_dat(byte_dat),
    .o_tx_dat(tx_dat), .i_ret_dat(ret_dat), .i_cam_dv(cam_dv), .i_cam_rst(cam_rst),
    .i_cam_dat(cam_dat), .o_out_vld(out_vld), .o_out_rst(out_rst), .o_out_dat(out_dat),
    .o_cfg(cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic c, input logic v, input logic [7:0] b, input logic [7:0] r,
                              input logic [7:0] tx, input logic [63:0] cf, input logic ov,
                              input logic [47:0] od);
    vec_t e;
    e.css = c; e.vld = v; e.b = b; e.ret = r; e.tx = tx; e.cfg = cf; e.ov = ov; e.od = od;
    tbl.push_back(e);
  endfunction

  task automatic cyc(input logic c, input logic v, input logic [7:0] b);
    css = c; byte_vld = v; byte_dat = b;
    @(posedge clk); #1;
    byte_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; css = 1'b0; byte_vld = 1'b0; byte_dat = 8'h00; ret_dat = 8'h00;
    cam_dv = 1'b1; cam_rst = 1'b1; cam_dat = CAM;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {56'h0, tx_dat}, 64'hFF);
    chk("rst_cfg", cfg, 64'h0);
    chk("rst_vld", {63'h0, out_vld}, 64'h1);
    chk("rst_orst", {63'h0, out_rst}, 64'h1);
    chk("rst_dat", {16'h0, out_dat}, {16'h0, CAM});
    cam_dv = 1'b0; cam_rst = 1'b0; rst = 1'b0;

    // Burst write from reg5 wrapping through status to reg0; reg0=C3 selects SPI source.
    add(1, 1, 8'h80, 8'h00, 8'hFF, 64'h0, 0, CAM);
    add(1, 1, 8'h05, 8'h00, 8'hFF, 64'h0, 0, CAM);
    add(1, 1, 8'h5A, 8'h00, 8'hFF, 64'h0000_5A00_0000_0000, 0, CAM);
    add(1, 1, 8'hA1, 8'h00, 8'hFF, 64'h00A1_5A00_0000_0000, 0, CAM);
    add(1, 1, 8'hB2, 8'h00, 8'hFF, 64'h00A1_5A00_0000_0000, 0, CAM);
    add(1, 1, 8'hC3, 8'h00, 8'hFF, CW, 0, 48'h0);
    add(0, 0, 8'h00, 8'h00, 8'hFF, CW, 0, 48'h0);
    // Burst read from reg5: reg5, reg6, status, reg0.
    add(1, 1, 8'h81, 8'h00, 8'hFF, CW, 0, 48'h0);
    add(1, 1, 8'h05, 8'h00, 8'h5A, CW, 0, 48'h0);
    add(1, 1, 8'h33, 8'h00, 8'hA1, CW, 0, 48'h0);
    add(1, 1, 8'h33, 8'h00, 8'h00, CW, 0, 48'h0);
    add(1, 1, 8'h33, 8'h00, 8'hC3, CW, 0, 48'h0);
    add(0, 0, 8'h00, 8'h00, 8'hC3, CW, 0, 48'h0);
    // Two full pixels streamed, tx echoes ret_dat.
    add(1, 1, 8'h55, 8'h00, 8'hFF, CS, 0, 48'h0);
    for (int i = 1; i <= 12; i++) begin
      add(1, 1, 8'(i), 8'(8'hE0 + i), 8'(8'hE0 + i), CS, (i == 6 || i == 12),
          (i < 6) ? 48'h0 : ((i < 12) ? PIX1 : PIX2));
    end
    add(0, 0, 8'h00, 8'h00, 8'hEC, CW, 0, PIX2);

    for (int i = 0; i < tbl.size(); i++) begin
      css = tbl[i].css; byte_vld = tbl[i].vld; byte_dat = tbl[i].b; ret_dat = tbl[i].ret;
      @(posedge clk); #1;
      byte_vld = 1'b0;
      chk($sformatf("vec%0d_tx", i), {56'h0, tx_dat}, {56'h0, tbl[i].tx});
      chk($sformatf("vec%0d_cfg", i), cfg, tbl[i].cfg);
      chk($sformatf("vec%0d_vld", i), {63'h0, out_vld}, {63'h0, tbl[i].ov});
      chk($sformatf("vec%0d_dat", i), {16'h0, out_dat}, {16'h0, tbl[i].od});
    end
    ret_dat = 8'h00;

    // Partial pixel sets sticky perr, readable and cleared by a status write.
    cyc(1, 1, 8'h55);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 1, 8'(i));
      chk("part_novld", {63'h0, out_vld}, 64'h0);
    end
    cyc(0, 0, 8'h00);
    chk("part_perr", {56'h0, cfg[63:56]}, 64'h01);
    chk("part_novld_end", {63'h0, out_vld}, 64'h0);
    cyc(1, 1, 8'h81);
    cyc(1, 1, 8'h07);
    chk("part_rd_stat", {56'h0, tx_dat}, 64'h01);
    cyc(0, 0, 8'h00);
    cyc(1, 1, 8'h80);
    cyc(1, 1, 8'h07);
    cyc(1, 1, 8'h00);
    chk("part_clr", {56'h0, cfg[63:56]}, 64'h00);
    chk("part_regs_kept", {8'h0, cfg[55:0]}, {8'h0, CW[55:0]});
    cyc(0, 0, 8'h00);

    // A byte arriving with css low is ignored.
    cyc(0, 1, 8'h80);
    cyc(1, 1, 8'h81);
    cyc(1, 1, 8'h05);
    chk("css0_byte_ign", {56'h0, tx_dat}, 64'h5A);
    cyc(0, 0, 8'h00);

    // Screen reset and source mux.
    cyc(1, 1, 8'h41);
    chk("scr_tx", {56'h0, tx_dat}, 64'hFF);
    chk("scr_orst", {63'h0, out_rst}, 64'h1);
    chk("scr_stat", {63'h0, cfg[58]}, 64'h1);
    cyc(0, 0, 8'h00);
    chk("scr_kept", {63'h0, out_rst}, 64'h1);
    cyc(1, 1, 8'h80);
    cyc(1, 1, 8'h00);
    cyc(1, 1, 8'h00);
    chk("mux_cam_rst0", {63'h0, out_rst}, 64'h0);
    cyc(0, 0, 8'h00);
    cam_rst = 1'b1; cam_dv = 1'b1;
    #1;
    chk("mux_cam_rst1", {63'h0, out_rst}, 64'h1);
    chk("mux_cam_dv", {63'h0, out_vld}, 64'h1);
    chk("mux_cam_dat", {16'h0, out_dat}, {16'h0, CAM});
    cam_rst = 1'b0; cam_dv = 1'b0;
    cyc(1, 1, 8'h40);
    chk("scr_clr", {63'h0, cfg[58]}, 64'h0);
    cyc(0, 0, 8'h00);

    // Reset in the middle of a pixel.
    cyc(1, 1, 8'h80);
    cyc(1, 1, 8'h00);
    cyc(1, 1, 8'h01);
    cyc(0, 0, 8'h00);
    chk("spi_pix_hold", {16'h0, out_dat}, {16'h0, PIX2});
    cyc(1, 1, 8'h55);
    cyc(1, 1, 8'h01);
    cyc(1, 1, 8'h02);
    cyc(1, 1, 8'h03);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_cfg", cfg, 64'h0);
    chk("mrst_tx", {56'h0, tx_dat}, 64'hFF);
    chk("mrst_vld", {63'h0, out_vld}, 64'h0);
    chk("mrst_dat", {16'h0, out_dat}, {16'h0, CAM});
    rst = 1'b0;
    cyc(1, 1, 8'h04);
    cyc(1, 1, 8'h05);
    cyc(1, 1, 8'h06);
    chk("mrst_nopulse", {63'h0, out_vld}, 64'h0);
    cyc(0, 0, 8'h00);
    chk("mrst_noperr", cfg, 64'h0);
    cyc(1, 1, 8'h80);
    cyc(1, 1, 8'h00);
    cyc(1, 1, 8'h01);
    chk("mrst_spipix0", {16'h0, out_dat}, 64'h0);
    chk("mrst_spivld0", {63'h0, out_vld}, 64'h0);
    cyc(0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_pix_injector.md
# spi_pix_injector

Parametrised SPI command/pixel-injection front end for the SIFT pipeline. Consumes bytes already deserialised by `SPI_slave`, decodes register read/write, pixel-stream and screen-reset commands, and assembles multi-byte pixels. Muxes pixel valid, data and frame reset between the camera port and the SPI stream, feeding `PixCoordinator` and `octaveModule`. Adds burst register access, a configurable pixel width, a status register and partial-pixel error detection.

## Interface
- `PIX_BYTES`, 6: bytes per injected pixel, must be ≥1.
- `REG_AW`, 3: register address width; REG_N = 2**REG_AW registers of 8 bits.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `css`  in  1  SPI select, 1 = transaction active; low ends the transaction.
- `byte_vld`  in  1  one-cycle pulse, new received byte.
- `byte_dat`  in  8  received byte.
- `tx_dat`  out  8  byte to shift out on the next SPI byte.
- `ret_dat`  in  8  processed-data byte returned while streaming.
- `cam_dv`, `cam_rst`  in  1 each  camera pixel valid / frame reset.
- `cam_dat`  in  PIX_BYTES*8  camera pixel, zero-extended by the parent.
- `out_vld`, `out_rst`  out  1 each  selected pixel valid / frame reset.
- `out_dat`  out  PIX_BYTES*8  selected pixel.
- `cfg_o`  out  REG_N*8  flat register bank; register k is `cfg_o[k*8+:8]`.

## Operation
- States: IDLE, CMD_WR_A, WR_BURST, CMD_RD_A, RD_BURST, STREAM, DROP.
- Sampled `css`=0 forces IDLE and clears the byte and pixel counters. Registers and `scr_rst` are kept.
- IDLE, first byte is the opcode:
  - 0x80 → CMD_WR_A.
  - 0x81 → CMD_RD_A.
  - 0x55 → STREAM.
  - 0x40 → `scr_rst`=0, then DROP.
  - 0x41 → `scr_rst`=1, then DROP.
  - any other value → DROP.
  - `tx_dat`=0xFF after every opcode.
- CMD_WR_A: latch `ptr`=byte → WR_BURST.
- WR_BURST: each byte writes reg[`ptr`], then `ptr`=`ptr`+1 mod REG_N.
  - Writes to reg[REG_N-1] (status) do not store data; any write clears status bit0.
- CMD_RD_A: `tx_dat`=reg[byte], `ptr`=byte+1 → RD_BURST.
- RD_BURST: each byte gives `tx_dat`=reg[`ptr`], then `ptr`++ mod REG_N. Incoming data is ignored.
- STREAM: bytes shift into `pix_sr`, first byte ends up in the MSB.
  - Counter `bc` runs 0..PIX_BYTES-1.
  - On the byte with `bc`=PIX_BYTES-1: `spi_pix`={`pix_sr`,byte}, pulse `spi_vld`, `bc`=0.
  - Every byte gives `tx_dat`=`ret_dat`, sampled in the `byte_vld` cycle.
- DROP: ignore bytes, `tx_dat`=0xFF.
- Partial pixel: `css` low while STREAM and `bc`≠0 sets sticky status bit0 (`perr`). The partial pixel is discarded.
- Status reg[REG_N-1], read-only: bit0 `perr`, bit1 state==STREAM, bit2 `scr_rst`, bits 7:3 = 0.
- Source select `src_spi`=reg[0] bit0:
  - `src_spi`=1: `out_vld`=`spi_vld`, `out_dat`=`spi_pix`, `out_rst`=`scr_rst`.
  - `src_spi`=0: camera signals pass through combinationally.

## Timing
- Reset values: all registers 0; `tx_dat`=0xFF; state IDLE; `scr_rst`, `spi_vld`, `perr` = 0; `spi_pix`=0; `out_*` follow the camera inputs.
- `tx_dat` is registered and updates the cycle after `byte_vld`. It must be stable before the next SPI byte starts.
- Register writes are visible on `cfg_o` the cycle after `byte_vld`.
- `spi_vld` is a one-cycle pulse in the cycle after the last pixel byte's `byte_vld`. `spi_pix` holds until the next pixel.
- `byte_vld` in the same cycle as `css`=0: the byte is ignored and the transaction-end rules apply.
- `rst` overrides everything, including a mid-stream or mid-burst transaction. No `perr` is set by reset.
- Changing `src_spi` mid-frame switches the source on the next cycle. No pulse is synthesised.
- `PIX_BYTES`=1: every stream byte yields a pixel and `perr` can never be set.

## Test plan
- Burst write: css=1, bytes 0x80,0x06,0xA1,0xB2,0xC3 (REG_AW=3) → reg6=0xA1; reg7 write only clears `perr`; reg0=0xC3 (wrap). `cfg_o` updates one cycle after each byte.
- Burst read: 0x81,0x05 then 3 dummy bytes → `tx_dat` sequence 0xFF, reg5, reg6, status, reg0.
- Stream: write reg0=0x01; 0x55 then 12 bytes 0x01..0x0C → two `out_vld` pulses, `out_dat`=0x010203040506 then 0x0708090A0B0C; `tx_dat` echoes `ret_dat`.
- Partial pixel: 0x55 plus 4 bytes, then css=0 → no `out_vld`; read status gives bit0=1; writing 0x80,0x07,0x00 clears it to 0.
- Screen reset and mux: 0x41 → `out_rst`=1 while `src_spi`=1, status bit2=1; `src_spi`=0 → `out_rst`=`cam_rst`; 0x40 → `scr_rst`=0.
- Reset mid-stream: `rst` after 3 pixel bytes → state IDLE, `cfg_o`=0, `tx_dat`=0xFF, `perr`=0, no pulse.
